// File: rtl/mysystem_pio_gpio.sv
// Bidirectional Avalon-MM PIO: per-bit direction, atomic set/clear of outputs,
// synchronised inputs, sticky edge capture and a maskable level interrupt.
module mysystem_pio_gpio #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_OUT   = WIDTH'(8'hFF),
   parameter logic [WIDTH-1:0] RESET_DIR   = '0,
   parameter int               EDGE_TYPE   = 0,
   parameter int               SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe,
   output logic             irq
);
   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
   logic [WIDTH-1:0]                  r_prev;
   logic [WIDTH-1:0]                  r_edge;
   logic [WIDTH-1:0]                  r_data;
   logic [WIDTH-1:0]                  r_dir;
   logic [WIDTH-1:0]                  r_mask;
   logic [WIDTH-1:0]                  r_cap;
   logic                              r_irq;

   logic                              w_wr;
   logic [WIDTH-1:0]                  w_wd;
   logic [WIDTH-1:0]                  w_sync_in;
   logic [WIDTH-1:0]                  w_rise;
   logic [WIDTH-1:0]                  w_fall;
   logic [WIDTH-1:0]                  w_edge;
   logic [WIDTH-1:0]                  w_cap_clr;
   logic [WIDTH-1:0]                  w_rd;
   logic                              w_unused_wdata;

   assign w_wr           = chipselect & ~write_n;
   assign w_wd           = writedata[WIDTH-1:0];
   assign w_unused_wdata = ^writedata;
   assign w_sync_in      = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '0;
         r_prev <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
         r_prev <= w_sync_in;
      end
   end

   assign w_rise = w_sync_in & ~r_prev;
   assign w_fall = ~w_sync_in & r_prev;

   always_comb begin
      case (EDGE_TYPE)
         1:       w_edge = w_fall;
         2:       w_edge = w_rise | w_fall;
         default: w_edge = w_rise;
      endcase
   end

   // Detected edges are registered once, so a pin change first sampled at
   // edge k lands in the capture register at edge k+SYNC_STAGES+1.
   assign w_cap_clr = (w_wr && address == ADDR_EDGECAP) ? w_wd : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_edge <= '0;
         r_cap  <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_edge <= w_edge;
         r_cap  <= (r_cap & ~w_cap_clr) | r_edge;
         r_irq  <= |(r_cap & r_mask);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data <= RESET_OUT;
         r_dir  <= RESET_DIR;
         r_mask <= '0;
      end else if (w_wr) begin
         case (address)
            ADDR_DATA:    r_data <= w_wd;
            ADDR_DIR:     r_dir  <= w_wd;
            ADDR_IRQMASK: r_mask <= w_wd;
            ADDR_OUTSET:  r_data <= r_data | w_wd;
            ADDR_OUTCLR:  r_data <= r_data & ~w_wd;
            default:      ;
         endcase
      end
   end

   always_comb begin
      w_rd = '0;
      case (address)
         ADDR_DATA:    w_rd = (r_dir & r_data) | (~r_dir & w_sync_in);
         ADDR_DIR:     w_rd = r_dir;
         ADDR_IRQMASK: w_rd = r_mask;
         ADDR_EDGECAP: w_rd = r_cap;
         default:      w_rd = '0;
      endcase
   end

   assign readdata = 32'(w_rd);
   assign out_port = r_data;
   assign oe       = r_dir;
   assign irq      = r_irq;
endmodule

// File: tb/tb_mysystem_pio_gpio.sv
// Bench for mysystem_pio_gpio: directed scenarios plus randomized traffic on a
// rising-edge and an any-edge instance, checked against a history-based model.
module tb_mysystem_pio_gpio;
   localparam int W = 8;
   localparam int S = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [W-1:0]  in_port;

   logic [31:0]   rd_r, rd_a;
   logic [W-1:0]  out_r, out_a, oe_r, oe_a;
   logic          irq_r, irq_a;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mysystem_pio_gpio #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S)) dut_rise (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_r), .in_port(in_port),
      .out_port(out_r), .oe(oe_r), .irq(irq_r));

   mysystem_pio_gpio #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S)) dut_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_port),
      .out_port(out_a), .oe(oe_a), .irq(irq_a));

   // Reference model; index 0 = rising-edge instance, 1 = any-edge instance.
   logic [W-1:0] m_data, m_dir, m_mask;
   logic [W-1:0] m_cap [2];
   logic         m_irq [2];
   logic [W-1:0] m_hist [$];   // in_port as sampled at each edge, newest first

   function automatic logic [W-1:0] edges_of(int etype, logic [W-1:0] cur, logic [W-1:0] old);
      if (etype == 0) return cur & ~old;
      if (etype == 1) return ~cur & old;
      return cur ^ old;
   endfunction

   task automatic model_reset();
      m_data = 8'hFF; m_dir = '0; m_mask = '0;
      for (int k = 0; k < 2; k++) begin m_cap[k] = '0; m_irq[k] = 1'b0; end
      m_hist.delete();
      for (int i = 0; i < S + 2; i++) m_hist.push_back('0);
   endtask

   // A pin value sampled S+1 edges ago, compared with the one before it,
   // becomes visible in the capture register at this edge.
   task automatic model_edge();
      logic         wr;
      logic [W-1:0] wd, clr;
      if (!reset_n) begin model_reset(); return; end
      wr  = chipselect && !write_n;
      wd  = writedata[W-1:0];
      clr = (wr && address == 3'd3) ? wd : '0;
      for (int k = 0; k < 2; k++) begin
         m_irq[k] = |(m_cap[k] & m_mask);
         m_cap[k] = (m_cap[k] & ~clr) | edges_of(k == 0 ? 0 : 2, m_hist[S], m_hist[S+1]);
      end
      if (wr) begin
         case (address)
            3'd0: m_data = wd;
            3'd1: m_dir  = wd;
            3'd2: m_mask = wd;
            3'd4: m_data = m_data | wd;
            3'd5: m_data = m_data & ~wd;
            default: ;
         endcase
      end
      m_hist.push_front(in_port);
      void'(m_hist.pop_back());
   endtask

   function automatic logic [31:0] exp_read(int k, logic [2:0] a);
      logic [W-1:0] v;
      case (a)
         3'd0:    v = (m_dir & m_data) | (~m_dir & m_hist[S-1]);
         3'd1:    v = m_dir;
         3'd2:    v = m_mask;
         3'd3:    v = m_cap[k];
         default: v = '0;
      endcase
      return {24'h0, v};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      address = '0; writedata = '0; in_port = '0;
      model_reset();
      repeat (3) tick();
      checks++; if (out_r !== 8'hFF) begin errors++; $display("FAIL reset_out: got %h expected ff", out_r); end
      checks++; if (oe_r !== 8'h00) begin errors++; $display("FAIL reset_oe: got %h expected 00", oe_r); end
      checks++; if (irq_r !== 1'b0 || irq_a !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b/%b expected 0", irq_r, irq_a); end
      for (int a = 0; a < 8; a++) begin
         address = 3'(a); #1;
         checks++;
         if (rd_r !== 32'h0 || rd_a !== 32'h0) begin
            errors++; $display("FAIL reset_read addr %0d: got %h/%h expected 0", a, rd_r, rd_a);
         end
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_data_dir();
      bus_write(3'd1, 32'h0F);
      bus_write(3'd0, 32'hA5);
      in_port = 8'h30;
      repeat (S + 1) tick();
      checks++; if (oe_r !== 8'h0F) begin errors++; $display("FAIL dir_oe: got %h expected 0f", oe_r); end
      checks++; if (out_r !== 8'hA5) begin errors++; $display("FAIL data_out: got %h expected a5", out_r); end
      address = 3'd0; #1;
      checks++; if (rd_r !== 32'h35) begin errors++; $display("FAIL data_read: got %h expected 35", rd_r); end
      checks++; if (rd_a !== exp_read(1, 3'd0)) begin errors++; $display("FAIL data_read_any: got %h expected %h", rd_a, exp_read(1, 3'd0)); end
   endtask

   task automatic test_set_clr();
      bus_write(3'd4, 32'h0A);
      checks++; if (out_r !== 8'hAF) begin errors++; $display("FAIL outset: got %h expected af", out_r); end
      bus_write(3'd5, 32'h81);
      checks++; if (out_r !== 8'h2E) begin errors++; $display("FAIL outclr: got %h expected 2e", out_r); end
      address = 3'd4; #1;
      checks++; if (rd_r !== 32'h0) begin errors++; $display("FAIL outset_read: got %h expected 0", rd_r); end
      address = 3'd5; #1;
      checks++; if (rd_r !== 32'h0) begin errors++; $display("FAIL outclr_read: got %h expected 0", rd_r); end
   endtask

   task automatic test_edge_irq();
      in_port = 8'h00;
      repeat (6) tick();
      bus_write(3'd3, 32'hFF);
      bus_write(3'd2, 32'h01);
      address = 3'd3; #1;
      checks++; if (rd_r !== 32'h0 || rd_a !== 32'h0) begin errors++; $display("FAIL cap_cleared: got %h/%h expected 0", rd_r, rd_a); end
      in_port = 8'h01;
      repeat (3) tick();   // edges k, k+1, k+2
      checks++; if (rd_r !== 32'h0) begin errors++; $display("FAIL cap_early: got %h expected 0 at k+2", rd_r); end
      tick();              // edge k+3
      checks++; if (rd_r !== 32'h1 || rd_a !== 32'h1) begin errors++; $display("FAIL cap_set: got %h/%h expected 1 at k+3", rd_r, rd_a); end
      checks++; if (irq_r !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0 at k+3", irq_r); end
      tick();              // edge k+4
      checks++; if (irq_r !== 1'b1 || irq_a !== 1'b1) begin errors++; $display("FAIL irq_set: got %b/%b expected 1 at k+4", irq_r, irq_a); end
      bus_write(3'd3, 32'h01);
      address = 3'd3; #1;
      checks++; if (rd_r !== 32'h0 || irq_r !== 1'b1) begin errors++; $display("FAIL w1c: got cap %h irq %b expected cap 0 irq 1", rd_r, irq_r); end
      tick();
      checks++; if (irq_r !== 1'b0 || irq_a !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b/%b expected 0", irq_r, irq_a); end
   endtask

   task automatic test_collision();
      in_port = 8'h00;
      repeat (6) tick();
      in_port = 8'h01;
      repeat (6) tick();
      checks++; if (irq_r !== 1'b1) begin errors++; $display("FAIL coll_setup: got irq %b expected 1", irq_r); end
      in_port = 8'h00;
      repeat (2) tick();
      in_port = 8'h01;
      repeat (3) tick();          // edges k, k+1, k+2
      bus_write(3'd3, 32'h01);    // lands on edge k+3, same edge as the new capture
      address = 3'd3; #1;
      checks++; if (rd_r !== 32'h1 || rd_a !== 32'h1) begin errors++; $display("FAIL set_wins: got %h/%h expected 1", rd_r, rd_a); end
      tick();
      checks++; if (irq_r !== 1'b1 || irq_a !== 1'b1) begin errors++; $display("FAIL set_wins_irq: got %b/%b expected 1", irq_r, irq_a); end
   endtask

   task automatic test_reset_mid();
      in_port = 8'h08;
      repeat (6) tick();
      bus_write(3'd3, 32'hFF);
      in_port = 8'h00;
      repeat (2) tick();          // falling edge on bit 3 still inside the synchroniser
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      address = 3'd3; #1;
      checks++; if (out_r !== 8'hFF || oe_r !== 8'h00) begin errors++; $display("FAIL midrst_regs: got out %h oe %h expected ff/00", out_r, oe_r); end
      checks++; if (irq_r !== 1'b0 || rd_a !== 32'h0) begin errors++; $display("FAIL midrst_cap: got irq %b cap %h expected 0/0", irq_r, rd_a); end
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (8) tick();
      checks++; if (rd_r !== 32'h0 || rd_a !== 32'h0) begin errors++; $display("FAIL postrst_cap: got %h/%h expected 0", rd_r, rd_a); end
      address = 3'd2; #1;
      checks++; if (rd_r !== 32'h0 || irq_a !== 1'b0) begin errors++; $display("FAIL postrst_mask: got %h irq %b expected 0", rd_r, irq_a); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         in_port    = W'($urandom);
         chipselect = ($urandom_range(0, 2) != 0);
         write_n    = ($urandom_range(0, 1) != 0);
         address    = 3'($urandom_range(0, 7));
         writedata  = $urandom;
         tick();
         checks++;
         if (out_r !== m_data || out_a !== m_data || oe_r !== m_dir || oe_a !== m_dir) begin
            errors++; $display("FAIL rand_out n=%0d: got out %h/%h oe %h/%h expected %h/%h", n, out_r, out_a, oe_r, oe_a, m_data, m_dir);
         end
         checks++;
         if (irq_r !== m_irq[0] || irq_a !== m_irq[1]) begin
            errors++; $display("FAIL rand_irq n=%0d: got %b/%b expected %b/%b", n, irq_r, irq_a, m_irq[0], m_irq[1]);
         end
         checks++;
         if (rd_r !== exp_read(0, address) || rd_a !== exp_read(1, address)) begin
            errors++; $display("FAIL rand_read n=%0d addr %0d: got %h/%h expected %h/%h", n, address, rd_r, rd_a, exp_read(0, address), exp_read(1, address));
         end
      end
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_data_dir();
      test_set_clr();
      test_edge_irq();
      test_collision();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
